btb_assoc: RTL

- Tagged, set-associative branch target buffer for the CVA6 frontend; successor to the direct-mapped, untagged BTB.
- Adds per-entry tags against aliasing, N-way sets with round-robin replacement, and a synchronous (BRAM-friendly) read.
- Adds a sequential flush walker, so storage mapped to block RAM can be flushed on FPGA as well as ASIC.
- Sits between the IF-stage PC generator (lookup) and the branch unit (update on mispredict).

---
 rtl/btb_assoc_if.sv | 28 ++
 rtl/btb_assoc.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/btb_assoc_if.sv
// Lookup/update/prediction bundle between the IF-stage PC generator, the branch
// unit and btb_assoc. The frontend side uses master, the BTB uses slave.
interface btb_assoc_if #(
  parameter int VLEN            = 39,
  parameter int INSTR_PER_FETCH = 2
);
  logic                            flush_i;
  logic                            debug_mode_i;
  logic [VLEN-1:0]                 vpc_i;
  logic                            update_valid_i;
  logic [VLEN-1:0]                 update_pc_i;
  logic [VLEN-1:0]                 update_target_i;
  logic                            ready_o;
  logic [INSTR_PER_FETCH-1:0]      pred_valid_o;
  logic [INSTR_PER_FETCH*VLEN-1:0] pred_target_o;
  logic [31:0]                     hit_cnt_o;
  logic [31:0]                     evict_cnt_o;

  modport master (
    output flush_i, debug_mode_i, vpc_i, update_valid_i, update_pc_i, update_target_i,
    input  ready_o, pred_valid_o, pred_target_o, hit_cnt_o, evict_cnt_o
  );

  modport slave (
    input  flush_i, debug_mode_i, vpc_i, update_valid_i, update_pc_i, update_target_i,
    output ready_o, pred_valid_o, pred_target_o, hit_cnt_o, evict_cnt_o
  );
endinterface

// File: rtl/btb_assoc.sv
// Tagged set-associative BTB with synchronous read, round-robin replacement and a
// sequential flush walker. Define BTB_ASSOC_PERF_CNT_EN to build hit/eviction counters.
module btb_assoc #(
  parameter int VLEN            = 39,
  parameter int INSTR_PER_FETCH = 2,
  parameter int OFFSET          = 1,
  parameter int NR_SETS         = 16,
  parameter int NR_WAYS         = 2,
  parameter int TAG_BITS        = 8
) (
  input  logic      clk_i,
  input  logic      rst_i,
  btb_assoc_if.slave bus
);

  localparam int SB        = OFFSET + $clog2(INSTR_PER_FETCH);
  localparam int SLOT_BITS = (INSTR_PER_FETCH > 1) ? $clog2(INSTR_PER_FETCH) : 1;
  localparam int SET_BITS  = $clog2(NR_SETS);
  localparam int WAY_BITS  = (NR_WAYS > 1) ? $clog2(NR_WAYS) : 1;

  typedef enum logic {
    FLUSH,
    IDLE
  } state_e;

  state_e state_q, state_d;
  logic [SET_BITS-1:0] flush_cnt_q, flush_cnt_d;
  logic [SET_BITS-1:0] flush_set;
  logic [WAY_BITS-1:0] rr_q [NR_SETS];
  logic                lookup_valid_q;

  // Entry storage has no reset so it can map onto block RAM; the walker clears valid.
  logic                entry_valid  [NR_SETS][NR_WAYS][INSTR_PER_FETCH];
  logic [TAG_BITS-1:0] entry_tag    [NR_SETS][NR_WAYS][INSTR_PER_FETCH];
  logic [VLEN-1:0]     entry_target [NR_SETS][NR_WAYS][INSTR_PER_FETCH];

  logic                rd_valid_q  [NR_WAYS][INSTR_PER_FETCH];
  logic [TAG_BITS-1:0] rd_tag_q    [NR_WAYS][INSTR_PER_FETCH];
  logic [VLEN-1:0]     rd_target_q [NR_WAYS][INSTR_PER_FETCH];
  logic [TAG_BITS-1:0] lk_tag_q;

  logic [SET_BITS-1:0]  lk_set;
  logic [SET_BITS-1:0]  upd_set;
  logic [SLOT_BITS-1:0] upd_slot;
  logic [TAG_BITS-1:0]  upd_tag;
  logic                 upd_en;
  logic                 upd_hit;
  logic                 upd_free;
  logic [WAY_BITS-1:0]  upd_hit_way;
  logic [WAY_BITS-1:0]  upd_free_way;
  logic [WAY_BITS-1:0]  upd_way;
  logic                 upd_evict;
  logic [WAY_BITS-1:0]  rr_next;

  logic                            lookup_active;
  logic [INSTR_PER_FETCH-1:0]      slot_hit;
  logic [INSTR_PER_FETCH*VLEN-1:0] pred_target_flat;

  logic unused_pc;
  assign unused_pc = ^{bus.vpc_i, bus.update_pc_i};

  assign lk_set   = bus.vpc_i[SB +: SET_BITS];
  assign upd_set  = bus.update_pc_i[SB +: SET_BITS];
  assign upd_tag  = bus.update_pc_i[SB+SET_BITS +: TAG_BITS];
  assign upd_slot = SLOT_BITS'((bus.update_pc_i >> OFFSET) & VLEN'(INSTR_PER_FETCH - 1));

  // Flush wins over a same-cycle update; updates are also dropped during the walk.
  assign upd_en = !rst_i && (state_q == IDLE) && bus.update_valid_i &&
                  !bus.debug_mode_i && !bus.flush_i;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    flush_set   = flush_cnt_q;
    unique case (state_q)
      FLUSH: begin
        // A flush arriving mid-walk clears set 0 this cycle and restarts from there.
        flush_set   = bus.flush_i ? '0 : flush_cnt_q;
        flush_cnt_d = flush_set + 1'b1;
        if (!bus.flush_i && (flush_cnt_q == SET_BITS'(NR_SETS - 1))) begin
          state_d     = IDLE;
          flush_cnt_d = '0;
        end
      end
      IDLE: begin
        if (bus.flush_i) begin
          state_d     = FLUSH;
          flush_cnt_d = '0;
        end
      end
      default: begin
        state_d     = FLUSH;
        flush_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    upd_hit      = 1'b0;
    upd_free     = 1'b0;
    upd_hit_way  = '0;
    upd_free_way = '0;
    // Descending scan so the lowest matching / lowest free way is the one kept.
    for (int w = NR_WAYS - 1; w >= 0; w--) begin
      if (entry_valid[upd_set][w][upd_slot] && (entry_tag[upd_set][w][upd_slot] == upd_tag)) begin
        upd_hit     = 1'b1;
        upd_hit_way = WAY_BITS'(w);
      end
      if (!entry_valid[upd_set][w][upd_slot]) begin
        upd_free     = 1'b1;
        upd_free_way = WAY_BITS'(w);
      end
    end
    if (upd_hit) begin
      upd_way = upd_hit_way;
    end else if (upd_free) begin
      upd_way = upd_free_way;
    end else begin
      upd_way = rr_q[upd_set];
    end
    upd_evict = upd_en && !upd_hit && !upd_free;
    rr_next   = (rr_q[upd_set] == WAY_BITS'(NR_WAYS - 1)) ? '0 : rr_q[upd_set] + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= FLUSH;
      flush_cnt_q    <= '0;
      lookup_valid_q <= 1'b0;
      for (int s = 0; s < NR_SETS; s++) begin
        rr_q[s] <= '0;
      end
    end else begin
      state_q        <= state_d;
      flush_cnt_q    <= flush_cnt_d;
      lookup_valid_q <= (state_q == IDLE);
      if (upd_evict) begin
        rr_q[upd_set] <= rr_next;
      end
    end
  end

  // Read port samples the old contents on a same-set write (read-first).
  always_ff @(posedge clk_i) begin
    if (state_q == FLUSH) begin
      for (int w = 0; w < NR_WAYS; w++) begin
        for (int s = 0; s < INSTR_PER_FETCH; s++) begin
          entry_valid[flush_set][w][s] <= 1'b0;
        end
      end
    end else if (upd_en) begin
      entry_valid[upd_set][upd_way][upd_slot]  <= 1'b1;
      entry_tag[upd_set][upd_way][upd_slot]    <= upd_tag;
      entry_target[upd_set][upd_way][upd_slot] <= bus.update_target_i;
    end
    for (int w = 0; w < NR_WAYS; w++) begin
      for (int s = 0; s < INSTR_PER_FETCH; s++) begin
        rd_valid_q[w][s]  <= entry_valid[lk_set][w][s];
        rd_tag_q[w][s]    <= entry_tag[lk_set][w][s];
        rd_target_q[w][s] <= entry_target[lk_set][w][s];
      end
    end
    lk_tag_q <= bus.vpc_i[SB+SET_BITS +: TAG_BITS];
  end

  assign lookup_active = lookup_valid_q && (state_q == IDLE);

  always_comb begin
    slot_hit         = '0;
    pred_target_flat = '0;
    for (int s = 0; s < INSTR_PER_FETCH; s++) begin
      for (int w = NR_WAYS - 1; w >= 0; w--) begin
        if (lookup_active && rd_valid_q[w][s] && (rd_tag_q[w][s] == lk_tag_q)) begin
          slot_hit[s]                      = 1'b1;
          pred_target_flat[s*VLEN +: VLEN] = rd_target_q[w][s];
        end
      end
    end
  end

  assign bus.ready_o       = (state_q == IDLE);
  assign bus.pred_valid_o  = slot_hit;
  assign bus.pred_target_o = pred_target_flat;

`ifdef BTB_ASSOC_PERF_CNT_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] evict_cnt_q;

  // Saturating counters; they survive flushes and clear only on reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_q   <= '0;
      evict_cnt_q <= '0;
    end else begin
      if ((|slot_hit) && (hit_cnt_q != 32'hFFFF_FFFF)) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (upd_evict && (evict_cnt_q != 32'hFFFF_FFFF)) begin
        evict_cnt_q <= evict_cnt_q + 32'd1;
      end
    end
  end

  assign bus.hit_cnt_o   = hit_cnt_q;
  assign bus.evict_cnt_o = evict_cnt_q;
`else
  logic unused_evict;
  assign unused_evict    = upd_evict;
  assign bus.hit_cnt_o   = '0;
  assign bus.evict_cnt_o = '0;
`endif

endmodule
